// File: rtl/gpmc_fifo_regs.sv
// Host register file behind the GPMC bridge: TX/RX word FIFOs, STATUS/CTRL/ID, interrupt.
// rd_data and irq are registered (1 cycle); a full TX FIFO drops host writes, a full RX FIFO deasserts rx_ready.
module gpmc_fifo_regs #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]      FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] ID_VAL   = DATA_WIDTH'(16'hF1F0);
    localparam logic [ADDR_WIDTH-1:0] A_TX     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_RX     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ST     = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(4);

    // Strobes only count while the chip is selected.
    logic we_s, oe_s;
    assign we_s = we | cs;
    assign oe_s = oe | cs;

    logic                  we_q, oe_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  wr_evt, rd_start, rd_end;
    logic                  ctrl_wr, tx_flush, rx_flush, clr_sticky;

    logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [FIFO_AW-1:0]    tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [FIFO_AW:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  tx_wr, tx_push, tx_pop, tx_ovf_set;
    logic                  rx_rd_end, rx_push, rx_pop, rx_unf_set;
    logic                  tx_ovf_q, rx_unf_q, irq_en_q, irq_q, irq_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, status;

    assign wr_evt   = we_q & ~we_s;
    assign rd_start = oe_q & ~oe_s;
    assign rd_end   = ~oe_q & oe_s;

    assign ctrl_wr    = wr_evt & (address == A_CTRL);
    assign tx_flush   = ctrl_wr & wr_data[1];
    assign rx_flush   = ctrl_wr & wr_data[2];
    assign clr_sticky = ctrl_wr & wr_data[3];

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem_q[tx_rd_q];
    assign rx_ready = ~rx_full;

    // A full TX FIFO still takes the write when the fabric frees a slot on the same edge.
    assign tx_wr      = wr_evt & (address == A_TX);
    assign tx_pop     = tx_valid & tx_ready;
    assign tx_push    = tx_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = tx_wr & tx_full & ~tx_pop;

    assign rx_push    = rx_valid & rx_ready;
    assign rx_rd_end  = rd_end & (rd_addr_q == A_RX);
    assign rx_pop     = rx_rd_end & ~rx_empty;
    assign rx_unf_set = rx_rd_end & rx_empty;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + (FIFO_AW+1)'(1);
        end else if (tx_pop && !tx_push) begin
            tx_cnt_d = tx_cnt_q - (FIFO_AW+1)'(1);
        end
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + (FIFO_AW+1)'(1);
        end else if (rx_pop && !rx_push) begin
            rx_cnt_d = rx_cnt_q - (FIFO_AW+1)'(1);
        end
    end

    always_comb begin
        status    = '0;
        status[0] = tx_full;
        status[1] = tx_empty;
        status[2] = rx_full;
        status[3] = rx_empty;
        status[4] = tx_ovf_q;
        status[5] = rx_unf_q;
        status[8 +: FIFO_AW+1] = rx_cnt_q;
        rd_data_d = '0;
        case (address)
            A_RX:    rd_data_d = rx_empty ? '0 : rx_mem_q[rx_rd_q];
            A_ST:    rd_data_d = status;
            A_CTRL:  rd_data_d[0] = irq_en_q;
            A_ID:    rd_data_d = ID_VAL;
            default: rd_data_d = '0;
        endcase
        irq_d = irq_en_q & (~rx_empty | tx_ovf_q | rx_unf_q);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= wr_data;
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b1;
            oe_q      <= 1'b1;
            rd_addr_q <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            we_q      <= we_s;
            oe_q      <= oe_s;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
            if (rd_start) rd_addr_q <= address;
            if (ctrl_wr)  irq_en_q  <= wr_data[0];
            // Flush wins over any same-edge push or pop on that FIFO.
            if (tx_flush) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wr_q <= tx_wr_q + FIFO_AW'(1);
                if (tx_pop)  tx_rd_q <= tx_rd_q + FIFO_AW'(1);
                tx_cnt_q <= tx_cnt_d;
            end
            if (rx_flush) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (rx_push) rx_wr_q <= rx_wr_q + FIFO_AW'(1);
                if (rx_pop)  rx_rd_q <= rx_rd_q + FIFO_AW'(1);
                rx_cnt_q <= rx_cnt_d;
            end
            tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~clr_sticky);
            rx_unf_q <= rx_unf_set | (rx_unf_q & ~clr_sticky);
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_q;
endmodule
